spmv_dot_lanes: RTL and testbench

//  Multi-lane signed fixed-point dot-product engine for the SpMV kernel; next generation of the single-lane dot unit.

---
 rtl/spmv_dot_lanes.sv | 239 +++++++++++++++++++++++
 tb/tb_spmv_dot_lanes.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_dot_lanes.sv
// rtl/spmv_dot_lanes.sv - multi-lane signed fixed-point dot-product engine with row accumulation and output FIFO
// Optional feature macro: SPMV_DOT_SAT_EN (saturating accumulation, per-row overflow flag on M_AXIS_OUT_tuser)

module spmv_dot_lanes #(
    parameter int LANES     = 4,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 96,
    parameter int CNT_W     = 32,
    parameter int OUT_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] S_AXIS_A_tdata,
    input  logic                    S_AXIS_A_tvalid,
    output logic                    S_AXIS_A_tready,
    input  logic [LANES*DATA_W-1:0] S_AXIS_B_tdata,
    input  logic                    S_AXIS_B_tvalid,
    output logic                    S_AXIS_B_tready,
    input  logic [CNT_W-1:0]        S_AXIS_TIMES_tdata,
    input  logic                    S_AXIS_TIMES_tvalid,
    output logic                    S_AXIS_TIMES_tready,
    output logic [ACC_W-1:0]        M_AXIS_OUT_tdata,
    output logic                    M_AXIS_OUT_tuser,
    output logic                    M_AXIS_OUT_tvalid,
    input  logic                    M_AXIS_OUT_tready,
    output logic                    busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
`ifdef SPMV_DOT_SAT_EN
    localparam int FIFO_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int FIFO_W = ACC_W;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_PUSH} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          beats_left_q;
    logic                      v1_q;
    logic                      v2_q;
    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic [FIFO_W-1:0]         mem [OUT_DEPTH];
    logic [FIFO_W-1:0]         fifo_wdata;
    logic [FIFO_W-1:0]         rd_word;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [FCNT_W-1:0]         count_q;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      times_rdy;
    logic                      times_hs;
    logic                      fire;
    logic                      push;
    logic                      pop;
`ifdef SPMV_DOT_SAT_EN
    logic signed [ACC_W:0]     acc_wide;
    logic                      acc_clamp;
    logic                      ovf_q;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FCNT_W'(OUT_DEPTH));

    // A new row is admitted only when the FIFO can take its result, so the pipeline never stalls
    assign times_rdy = !rst && (state_q == ST_IDLE) && !fifo_full;
    assign times_hs  = S_AXIS_TIMES_tvalid && times_rdy;

    // Join: both beat streams are consumed together or not at all
    assign fire = !rst && (state_q == ST_ACCUM) && (beats_left_q != '0)
                  && S_AXIS_A_tvalid && S_AXIS_B_tvalid;

    assign push = (state_q == ST_PUSH);
    assign pop  = M_AXIS_OUT_tvalid && M_AXIS_OUT_tready;

    assign S_AXIS_TIMES_tready = times_rdy;
    assign S_AXIS_A_tready     = fire;
    assign S_AXIS_B_tready     = fire;
    assign busy                = (state_q != ST_IDLE) || v1_q || v2_q;

    // Row sequencing: load beat count, consume beats, let the pipeline empty, push the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (times_hs) begin
                        beats_left_q <= S_AXIS_TIMES_tdata;
                        state_q      <= (S_AXIS_TIMES_tdata == '0) ? ST_PUSH : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beats_left_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (fire) begin
                        beats_left_q <= beats_left_q - CNT_W'(1);
                        if (beats_left_q == CNT_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!v1_q && !v2_q) begin
                        state_q <= ST_PUSH;
                    end
                end
                ST_PUSH: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Per-lane signed products at full 2*DATA_W precision
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'($signed(S_AXIS_A_tdata[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(S_AXIS_B_tdata[i*DATA_W +: DATA_W]));
        end
    end

    // Lane products reduced to one beat sum, wide enough that it cannot overflow
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    // Stage valids; only these are reset so a reset flushes in-flight beats
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= fire;
            v2_q <= v1_q;
        end
    end

    // Stage data registers, qualified by the matching valid
    always_ff @(posedge clk) begin
        if (fire) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
        if (v1_q) begin
            sum_q <= sum_d;
        end
    end

    // Accumulator next value: wrap by default, clamp to signed bounds when saturation is built in
    always_comb begin
        acc_d = acc_q + ACC_W'(sum_q);
`ifdef SPMV_DOT_SAT_EN
        acc_wide  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_q);
        acc_clamp = (acc_wide[ACC_W] != acc_wide[ACC_W-1]);
        if (acc_clamp) begin
            acc_d = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Row accumulator, cleared when the next row's beat count is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
`ifdef SPMV_DOT_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else if (times_hs) begin
            acc_q <= '0;
`ifdef SPMV_DOT_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else if (v2_q) begin
            acc_q <= acc_d;
`ifdef SPMV_DOT_SAT_EN
            ovf_q <= ovf_q | acc_clamp;
`endif
        end
    end

`ifdef SPMV_DOT_SAT_EN
    assign fifo_wdata = {ovf_q, acc_q};
`else
    assign fifo_wdata = acc_q;
`endif

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= fifo_wdata;
        end
    end

    // Result FIFO pointers and occupancy; a concurrent push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_word           = mem[rd_ptr_q];
    assign M_AXIS_OUT_tvalid = !fifo_empty;
    assign M_AXIS_OUT_tdata  = fifo_empty ? '0 : rd_word[ACC_W-1:0];
`ifdef SPMV_DOT_SAT_EN
    assign M_AXIS_OUT_tuser  = fifo_empty ? 1'b0 : rd_word[ACC_W];
`else
    assign M_AXIS_OUT_tuser  = 1'b0;
`endif

endmodule

// File: tb/tb_spmv_dot_lanes.sv
// tb/tb_spmv_dot_lanes.sv - self-checking bench for spmv_dot_lanes against an arithmetic row model

module tb_spmv_dot_lanes;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int AW    = 36;
    localparam int CW    = 32;
    localparam int DEPTH = 16;
    localparam longint MAXV  = (longint'(1) <<< (AW-1)) - 1;
    localparam longint MINV  = -(longint'(1) <<< (AW-1));
    localparam longint RANGE = longint'(1) <<< AW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES*DW-1:0]   a_tdata, b_tdata;
    logic                  a_tvalid, a_tready, b_tvalid, b_tready;
    logic [CW-1:0]         t_tdata;
    logic                  t_tvalid, t_tready;
    logic [AW-1:0]         o_tdata;
    logic                  o_tuser, o_tvalid, o_tready;
    logic                  busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          join_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] row_a[$];
    logic [63:0] row_b[$];

    always #5 clk = ~clk;

    spmv_dot_lanes #(
        .LANES(LANES), .DATA_W(DW), .ACC_W(AW), .CNT_W(CW), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .S_AXIS_A_tdata(a_tdata), .S_AXIS_A_tvalid(a_tvalid), .S_AXIS_A_tready(a_tready),
        .S_AXIS_B_tdata(b_tdata), .S_AXIS_B_tvalid(b_tvalid), .S_AXIS_B_tready(b_tready),
        .S_AXIS_TIMES_tdata(t_tdata), .S_AXIS_TIMES_tvalid(t_tvalid), .S_AXIS_TIMES_tready(t_tready),
        .M_AXIS_OUT_tdata(o_tdata), .M_AXIS_OUT_tuser(o_tuser), .M_AXIS_OUT_tvalid(o_tvalid),
        .M_AXIS_OUT_tready(o_tready), .busy(busy)
    );

    always @(negedge clk) begin
        if (!rst && o_tvalid && o_tready) got_q.push_back({27'b0, o_tuser, o_tdata});
        if ((a_tvalid && a_tready) != (b_tvalid && b_tready)) join_err++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
    endfunction

    // Row result from the definition: sum over beats of sum over lanes of A*B, wrapped or clamped per beat
    function automatic logic [63:0] model_row();
        longint acc = 0;
        longint s;
        longint r;
        logic ov = 1'b0;
        logic signed [DW-1:0] la, lb;
        logic [63:0] rr;
        for (int k = 0; k < row_a.size(); k++) begin
            s = 0;
            for (int i = 0; i < LANES; i++) begin
                la = row_a[k][i*DW +: DW];
                lb = row_b[k][i*DW +: DW];
                s += longint'(la) * longint'(lb);
            end
            r = acc + s;
`ifdef SPMV_DOT_SAT_EN
            if (r > MAXV) begin r = MAXV; ov = 1'b1; end
            else if (r < MINV) begin r = MINV; ov = 1'b1; end
`else
            if (r > MAXV) r -= RANGE;
            else if (r < MINV) r += RANGE;
`endif
            acc = r;
        end
        rr = acc;
        return {27'b0, ov, rr[AW-1:0]};
    endfunction

    task automatic fill_random(input int t);
        row_a = {};
        row_b = {};
        for (int k = 0; k < t; k++) begin
            row_a.push_back({$urandom, $urandom});
            row_b.push_back({$urandom, $urandom});
        end
    endtask

    task automatic send_times(input int t);
        int   n = 0;
        logic hs = 1'b0;
        t_tdata  = t;
        t_tvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = t_tready;
            step();
            n++;
        end
        t_tvalid = 1'b0;
        chk("times_timeout", {63'b0, !hs}, 64'd0);
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input int bdelay);
        int   n = 0;
        logic hs = 1'b0;
        a_tdata  = a;
        b_tdata  = b;
        a_tvalid = 1'b1;
        b_tvalid = (bdelay == 0);
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = a_tready;
            step();
            n++;
            if (n >= bdelay) b_tvalid = 1'b1;
        end
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        chk("beat_timeout", {63'b0, !hs}, 64'd0);
    endtask

    task automatic do_row(input int lead, input int maxgap);
        exp_q.push_back(model_row());
        send_times(row_a.size());
        for (int k = 0; k < row_a.size(); k++) begin
            send_beat(row_a[k], row_b[k], (k == 0) ? lead : $urandom_range(0, maxgap));
        end
    endtask

    task automatic expect_at(input string tag, input int idx, input logic [63:0] v);
        int n = 0;
        while (got_q.size() <= idx && n < 500) begin step(); n++; end
        chk(tag, (got_q.size() > idx) ? got_q[idx] : 64'hFFFF_FFFF_FFFF_FFFF, v);
    endtask

    task automatic check_all(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin step(); n++; end
        repeat (3) step();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
        exp_q = {};
        got_q = {};
    endtask

    initial begin
        rst = 1'b1; a_tvalid = 1'b0; b_tvalid = 1'b0; t_tvalid = 1'b0;
        a_tdata = '0; b_tdata = '0; t_tdata = '0; o_tready = 1'b1;
        repeat (3) step();
        chk("rst_times_tready", {63'b0, t_tready}, 64'd0);
        chk("rst_a_tready", {63'b0, a_tready}, 64'd0);
        chk("rst_out_tvalid", {63'b0, o_tvalid}, 64'd0);
        chk("rst_out_tdata", {27'b0, o_tuser, o_tdata}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_times_tready", {63'b0, t_tready}, 64'd1);
        chk("idle_busy", {63'b0, busy}, 64'd0);

        // three beats, all lanes equal to the beat number
        row_a = {}; row_b = {};
        for (int k = 1; k <= 3; k++) begin
            row_a.push_back(pack4(k, k, k, k));
            row_b.push_back(pack4(k, k, k, k));
        end
        do_row(0, 0);
        expect_at("dot56", 0, 64'd56);
        check_all("dot56_model");

        // empty row then a single negative row, in order
        row_a = {}; row_b = {};
        do_row(0, 0);
        row_a.push_back(pack4(-2, -2, -2, -2));
        row_b.push_back(pack4(3, 3, 3, 3));
        do_row(0, 0);
        expect_at("zero_row", 0, 64'd0);
        expect_at("neg24_row", 1, 64'h0000_000F_FFFF_FFE8);
        check_all("order_model");

        // A leads B by five cycles, random B gaps, random data
        for (int r = 0; r < 6; r++) begin
            fill_random($urandom_range(1, 6));
            do_row(5, 4);
        end
        check_all("gap_rows");
        chk("join_violations", join_err, 64'd0);

        // output stalled: sixteen rows fill the FIFO, a seventeenth is refused
        o_tready = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            fill_random(1);
            do_row(0, 1);
        end
        repeat (10) step();
        chk("full_no_pop", got_q.size(), 64'd0);
        chk("full_times_tready", {63'b0, t_tready}, 64'd0);
        chk("full_tvalid", {63'b0, o_tvalid}, 64'd1);
        chk("full_busy", {63'b0, busy}, 64'd0);
        t_tdata = 1;
        t_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("held_times_tready", {63'b0, t_tready}, 64'd0);
            chk("held_head", {27'b0, o_tuser, o_tdata}, exp_q[0]);
            step();
        end
        t_tvalid = 1'b0;
        o_tready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            fill_random(1);
            do_row(0, 1);
        end
        check_all("fifo20");

        // accumulate to the positive limit, then one more
        row_a = {}; row_b = {};
        for (int k = 0; k < 7; k++) begin
            row_a.push_back(pack4(-32768, -32768, -32768, -32768));
            row_b.push_back(pack4(-32768, -32768, -32768, -32768));
        end
        row_a.push_back(pack4(-32768, -32768, -32768, -32768));
        row_b.push_back(pack4(-32768, -32768, -32768, -32767));
        row_a.push_back(pack4(32767, 0, 0, 0));
        row_b.push_back(pack4(1, 0, 0, 0));
        row_a.push_back(pack4(1, 0, 0, 0));
        row_b.push_back(pack4(1, 0, 0, 0));
        do_row(0, 2);
`ifdef SPMV_DOT_SAT_EN
        expect_at("ovf_clamp", 0, 64'h0000_0017_FFFF_FFFF);
`else
        expect_at("ovf_wrap", 0, 64'h0000_0008_0000_0000);
`endif
        check_all("ovf_model");

        // reset mid-row with a result still queued
        o_tready = 1'b0;
        fill_random(2);
        do_row(0, 0);
        repeat (8) step();
        fill_random(4);
        send_times(4);
        send_beat(row_a[0], row_b[0], 0);
        send_beat(row_a[1], row_b[1], 1);
        rst = 1'b1;
        step();
        chk("midrst_tvalid", {63'b0, o_tvalid}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        rst = 1'b0;
        exp_q = {};
        got_q = {};
        o_tready = 1'b1;
        step();
        fill_random(3);
        do_row(1, 2);
        check_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
